// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit accumulator processor.
// State is registered; strobes are decoded from state, ir_op and mem_ready, and forced low during reset.
module cpu_sequencer #(
    parameter int OPW  = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [OPW-1:0]  ir_op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_load,
    output logic            ir_load,
    output logic            ir_out,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            acc_load,
    output logic            acc_out,
    output logic [1:0]      alu_op,
    output logic            out_load,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_F1, S_F2, S_DEC, S_E1, S_E2, S_JMP, S_OUT, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_LDA = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_ADD = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_SUB = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_STA = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_JMP = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_OUT = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_HLT = {OPW{1'b1}};

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA,
            OP_JMP, OP_JZ, OP_OUT, OP_HLT: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_F1:   state_d = S_F2;
            S_F2:   if (mem_ready) state_d = S_DEC;
            S_DEC: begin
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_E1;
                    OP_JMP:                         state_d = S_JMP;
                    OP_JZ:                          state_d = zero ? S_JMP : S_F1;
                    OP_OUT:                         state_d = S_OUT;
                    OP_HLT:                         state_d = S_HALT;
                    default:                        state_d = S_F1;
                endcase
            end
            S_E1:   state_d = S_E2;
            S_E2:   if (mem_ready) state_d = S_F1;
            S_JMP:  state_d = S_F1;
            S_OUT:  state_d = S_F1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_F1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_F1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DEC) cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign instr_count = cnt_q;

    // Strobe decode; every output is held low while reset is asserted.
    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        acc_load = 1'b0;
        acc_out  = 1'b0;
        alu_op   = 2'd0;
        out_load = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        if (nrst) begin
            case (state_q)
                S_F1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                S_F2: begin
                    mem_rd  = 1'b1;
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                S_DEC:  illegal = !op_legal(ir_op);
                S_E1: begin
                    ir_out   = 1'b1;
                    mar_load = 1'b1;
                end
                S_E2: begin
                    if (ir_op == OP_STA) begin
                        mem_wr  = 1'b1;
                        acc_out = 1'b1;
                    end else begin
                        mem_rd   = 1'b1;
                        acc_load = mem_ready;
                        if (mem_ready) begin
                            case (ir_op)
                                OP_ADD:  alu_op = 2'd1;
                                OP_SUB:  alu_op = 2'd2;
                                default: alu_op = 2'd0;
                            endcase
                        end
                    end
                end
                S_JMP: begin
                    ir_out  = 1'b1;
                    pc_load = 1'b1;
                end
                S_OUT: begin
                    acc_out  = 1'b1;
                    out_load = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed vector bench for cpu_sequencer: a per-cycle table of inputs and expected strobes/counter.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] ir_op;
    logic       zero;
    logic       mem_ready;

    logic pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out, mem_rd, mem_wr;
    logic acc_load, acc_out, out_load, halted, illegal;
    logic [1:0]  alu_op;
    logic [15:0] instr_count;

    logic s_pc_out, s_pc_inc, s_pc_load, s_mar_load, s_ir_load, s_ir_out, s_mem_rd, s_mem_wr;
    logic s_acc_load, s_acc_out, s_out_load, s_halted, s_illegal;
    logic [1:0] s_alu_op;
    logic [3:0] s_instr_count;

    cpu_sequencer #(.OPW(8), .CNTW(16)) dut (
        .clk(clk), .nrst(nrst), .ir_op(ir_op), .zero(zero), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ir_load(ir_load), .ir_out(ir_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .acc_load(acc_load), .acc_out(acc_out), .alu_op(alu_op), .out_load(out_load),
        .halted(halted), .illegal(illegal), .instr_count(instr_count)
    );

    // Narrow-counter instance shares all stimulus so its wrap is reached quickly.
    cpu_sequencer #(.OPW(8), .CNTW(4)) dut_small (
        .clk(clk), .nrst(nrst), .ir_op(ir_op), .zero(zero), .mem_ready(mem_ready),
        .pc_out(s_pc_out), .pc_inc(s_pc_inc), .pc_load(s_pc_load), .mar_load(s_mar_load),
        .ir_load(s_ir_load), .ir_out(s_ir_out), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
        .acc_load(s_acc_load), .acc_out(s_acc_out), .alu_op(s_alu_op), .out_load(s_out_load),
        .halted(s_halted), .illegal(s_illegal), .instr_count(s_instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] B_PC_OUT   = 15'h4000;
    localparam logic [14:0] B_PC_INC   = 15'h2000;
    localparam logic [14:0] B_PC_LOAD  = 15'h1000;
    localparam logic [14:0] B_MAR_LOAD = 15'h0800;
    localparam logic [14:0] B_IR_LOAD  = 15'h0400;
    localparam logic [14:0] B_IR_OUT   = 15'h0200;
    localparam logic [14:0] B_MEM_RD   = 15'h0100;
    localparam logic [14:0] B_MEM_WR   = 15'h0080;
    localparam logic [14:0] B_ACC_LOAD = 15'h0040;
    localparam logic [14:0] B_ACC_OUT  = 15'h0020;
    localparam logic [14:0] B_ALU_ADD  = 15'h0008;
    localparam logic [14:0] B_ALU_SUB  = 15'h0010;
    localparam logic [14:0] B_OUT_LOAD = 15'h0004;
    localparam logic [14:0] B_HALTED   = 15'h0002;
    localparam logic [14:0] B_ILLEGAL  = 15'h0001;

    localparam logic [14:0] O_NONE  = 15'h0000;
    localparam logic [14:0] O_F1    = B_PC_OUT | B_MAR_LOAD;
    localparam logic [14:0] O_F2W   = B_MEM_RD;
    localparam logic [14:0] O_F2R   = B_MEM_RD | B_IR_LOAD | B_PC_INC;
    localparam logic [14:0] O_E1    = B_IR_OUT | B_MAR_LOAD;
    localparam logic [14:0] O_E2W   = B_MEM_RD;
    localparam logic [14:0] O_LDA   = B_MEM_RD | B_ACC_LOAD;
    localparam logic [14:0] O_ADD   = B_MEM_RD | B_ACC_LOAD | B_ALU_ADD;
    localparam logic [14:0] O_SUB   = B_MEM_RD | B_ACC_LOAD | B_ALU_SUB;
    localparam logic [14:0] O_STA   = B_MEM_WR | B_ACC_OUT;
    localparam logic [14:0] O_JMP   = B_IR_OUT | B_PC_LOAD;
    localparam logic [14:0] O_OUT   = B_ACC_OUT | B_OUT_LOAD;
    localparam logic [14:0] O_HALT  = B_HALTED;
    localparam logic [14:0] O_ILL   = B_ILLEGAL;

    typedef struct {
        logic        rst_n;
        logic [7:0]  op;
        logic        z;
        logic        rdy;
        logic [14:0] exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;

    logic [14:0] outs;
    assign outs = {pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out, mem_rd, mem_wr,
                   acc_load, acc_out, alu_op, out_load, halted, illegal};
    logic [14:0] s_outs;
    assign s_outs = {s_pc_out, s_pc_inc, s_pc_load, s_mar_load, s_ir_load, s_ir_out, s_mem_rd,
                     s_mem_wr, s_acc_load, s_acc_out, s_alu_op, s_out_load, s_halted, s_illegal};

    function automatic void add(input logic rst_n, input logic [7:0] op, input logic z,
                                input logic rdy, input logic [14:0] exp, input logic [15:0] cnt);
        vec_t v;
        v.rst_n = rst_n; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.cnt = cnt;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, vidx, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [7:0] op, input logic z, input logic rdy);
        @(negedge clk);
        nrst = rst_n; ir_op = op; zero = z; mem_ready = rdy;
        #1;
    endtask

    // Adds a zero-wait fetch+decode starting at count c
    function automatic void fetch(input logic [7:0] op, input logic z, input logic [15:0] c,
                                  input logic [14:0] dec_exp);
        add(1'b1, op, 1'b0, 1'b1, O_F1,  c);
        add(1'b1, op, 1'b0, 1'b1, O_F2R, c);
        add(1'b1, op, z,    1'b1, dec_exp, c);
    endfunction

    initial begin
        nrst = 1'b0; ir_op = 8'h00; zero = 1'b0; mem_ready = 1'b1;

        add(1'b0, 8'h00, 1'b0, 1'b1, O_NONE, 16'd0);
        // Three NOPs
        fetch(8'h00, 1'b0, 16'd0, O_NONE);
        fetch(8'h00, 1'b0, 16'd1, O_NONE);
        fetch(8'h00, 1'b0, 16'd2, O_NONE);
        // LDA with three E2 wait cycles
        fetch(8'h01, 1'b0, 16'd3, O_NONE);
        add(1'b1, 8'h01, 1'b0, 1'b1, O_E1,  16'd4);
        add(1'b1, 8'h01, 1'b0, 1'b0, O_E2W, 16'd4);
        add(1'b1, 8'h01, 1'b0, 1'b0, O_E2W, 16'd4);
        add(1'b1, 8'h01, 1'b0, 1'b0, O_E2W, 16'd4);
        add(1'b1, 8'h01, 1'b0, 1'b1, O_LDA, 16'd4);
        // SUB then STA
        fetch(8'h03, 1'b0, 16'd4, O_NONE);
        add(1'b1, 8'h03, 1'b0, 1'b1, O_E1,  16'd5);
        add(1'b1, 8'h03, 1'b0, 1'b1, O_SUB, 16'd5);
        fetch(8'h04, 1'b0, 16'd5, O_NONE);
        add(1'b1, 8'h04, 1'b0, 1'b1, O_E1,  16'd6);
        add(1'b1, 8'h04, 1'b0, 1'b1, O_STA, 16'd6);
        // JZ untaken, JZ taken, JMP, OUT
        fetch(8'h06, 1'b0, 16'd6, O_NONE);
        fetch(8'h06, 1'b1, 16'd7, O_NONE);
        add(1'b1, 8'h06, 1'b0, 1'b1, O_JMP, 16'd8);
        fetch(8'h05, 1'b0, 16'd8, O_NONE);
        add(1'b1, 8'h05, 1'b0, 1'b1, O_JMP, 16'd9);
        fetch(8'h07, 1'b0, 16'd9, O_NONE);
        add(1'b1, 8'h07, 1'b0, 1'b1, O_OUT, 16'd10);
        // ADD with one fetch wait; mem_ready low in F1 is ignored
        add(1'b1, 8'h02, 1'b0, 1'b0, O_F1,  16'd10);
        add(1'b1, 8'h02, 1'b0, 1'b0, O_F2W, 16'd10);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_F2R, 16'd10);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_NONE, 16'd10);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_E1,  16'd11);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_ADD, 16'd11);
        // Illegal opcode
        fetch(8'h42, 1'b0, 16'd11, O_ILL);
        // ADD reset during E2 wait
        fetch(8'h02, 1'b0, 16'd12, O_NONE);
        add(1'b1, 8'h02, 1'b0, 1'b0, O_E1,  16'd13);
        add(1'b1, 8'h02, 1'b0, 1'b0, O_E2W, 16'd13);
        add(1'b0, 8'h02, 1'b0, 1'b0, O_NONE, 16'd13);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_F1,  16'd0);
        add(1'b1, 8'h02, 1'b0, 1'b1, O_F2R, 16'd0);
        add(1'b1, 8'h42, 1'b0, 1'b1, O_ILL, 16'd0);
        // HLT held for 20 cycles regardless of inputs
        fetch(8'hFF, 1'b0, 16'd1, O_NONE);
        for (int i = 0; i < 20; i++)
            add(1'b1, 8'hFF, i[0], i[1], O_HALT, 16'd2);
        add(1'b0, 8'hFF, 1'b0, 1'b1, O_NONE, 16'd2);
        // 17 NOPs: narrow counter wraps 15 -> 0
        for (int n = 0; n < 17; n++)
            fetch(8'h00, 1'b0, 16'(n), O_NONE);
        add(1'b1, 8'h00, 1'b0, 1'b1, O_F1, 16'd17);

        repeat (2) @(posedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            vidx = i;
            drive(tv[i].rst_n, tv[i].op, tv[i].z, tv[i].rdy);
            chk("strobes", 32'(outs), 32'(tv[i].exp));
            chk("instr_count", 32'(instr_count), 32'(tv[i].cnt));
            chk("instr_count_w4", 32'(s_instr_count), 32'(tv[i].cnt[3:0]));
            chk("narrow_strobes", 32'(s_outs), 32'(tv[i].exp));
            chk("bus_exclusive", 32'((32'(pc_out) + 32'(ir_out) + 32'(acc_out) + 32'(mem_rd)) <= 1), 32'd1);
        end

        // Hand sequence: reset while F2 waits drops the read request.
        vidx = -1;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("seq_f1", 32'(outs), 32'(O_F1));
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("seq_f2_wait", 32'(outs), 32'(O_F2W));
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        chk("seq_f2_wait2", 32'(outs), 32'(O_F2W));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("seq_rst_f2", 32'(outs), 32'(O_NONE));
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        chk("seq_after_rst", 32'(outs), 32'(O_F1));
        chk("seq_cnt", 32'(instr_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
